// File: rtl/uart_bfm_fifo.sv
// rtl/uart_bfm_fifo.sv - UART bench peer with configurable frame format, runtime divisor, TX/RX FIFOs and sticky errors
//
// uart_bfm_fifo_q : register-based FIFO, power-of-two depth, pointers wrap naturally.
//   push/wdata in, pop in, rdata (head entry), empty/full/count out.
//   A push on a full FIFO is accepted only when a pop happens in the same cycle.
//
// uart_bfm_fifo   : top level.
//   clk, rstb        clock, asynchronous active-low reset
//   cfg_div          bit period in clk cycles (0 selects CLKS_PER_BIT), latched per frame
//   rxd / txd        serial line from / to the DUT
//   tx_data/tx_valid/tx_ready/tx_count   transmit FIFO push side
//   rx_data/rx_valid/rx_ready/rx_count   receive FIFO pop side
//   err_frame/err_parity/err_overrun     sticky errors, err_clr clears them

module uart_bfm_fifo_q #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module uart_bfm_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_W        = 16
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          rxd,
    output logic                          txd,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          err_overrun,
    input  logic                          err_clr
);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    logic [DIV_W-1:0] eff_div;
    assign eff_div = (cfg_div == '0) ? DIV_W'(CLKS_PER_BIT) : cfg_div;

    // ---------------- TX ----------------
    logic                 tx_empty, tx_full, tx_pop, tx_load, tx_expire, tx_line, txd_q;
    logic [DATA_BITS-1:0] tx_head;
    state_t               tx_state, tx_state_nx;
    logic [DIV_W:0]       tx_cnt, tx_cnt_nx, tx_bit_len, tx_stop_len;
    logic [DIV_W-1:0]     tx_div, tx_div_nx;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
    logic [3:0]           tx_bit, tx_bit_nx;
    logic                 tx_par, tx_par_nx;

    uart_bfm_fifo_q #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (tx_valid && !tx_full),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    assign tx_ready    = !tx_full;
    assign tx_expire   = (tx_cnt == '0);
    assign tx_bit_len  = {1'b0, tx_div} - 1'b1;
    assign tx_stop_len = (STOP_BITS == 2) ? ({tx_div, 1'b0} - 1'b1) : tx_bit_len;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_div   <= tx_div_nx;
            tx_shift <= tx_shift_nx;
            tx_bit   <= tx_bit_nx;
            tx_par   <= tx_par_nx;
            txd_q    <= tx_line;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_expire ? tx_cnt : tx_cnt - 1'b1;
        tx_div_nx   = tx_div;
        tx_shift_nx = tx_shift;
        tx_bit_nx   = tx_bit;
        tx_par_nx   = tx_par;
        tx_pop      = 1'b0;
        tx_load     = 1'b0;
        case (tx_state)
            S_IDLE:  tx_load = !tx_empty;
            S_START: if (tx_expire) begin
                tx_state_nx = S_DATA;
                tx_cnt_nx   = tx_bit_len;
                tx_bit_nx   = '0;
            end
            S_DATA: if (tx_expire) begin
                tx_shift_nx = tx_shift >> 1;
                if (tx_bit == BIT_LAST) begin
                    tx_state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                    tx_cnt_nx   = (PARITY != 0) ? tx_bit_len : tx_stop_len;
                end else begin
                    tx_bit_nx = tx_bit + 1'b1;
                    tx_cnt_nx = tx_bit_len;
                end
            end
            S_PAR: if (tx_expire) begin
                tx_state_nx = S_STOP;
                tx_cnt_nx   = tx_stop_len;
            end
            S_STOP: if (tx_expire) begin
                tx_state_nx = S_IDLE;
                // Chain straight into the next frame so back-to-back bytes leave no idle gap.
                tx_load     = !tx_empty;
            end
            default: tx_state_nx = S_IDLE;
        endcase
        if (tx_load) begin
            tx_pop      = 1'b1;
            tx_state_nx = S_START;
            tx_div_nx   = eff_div;
            tx_cnt_nx   = {1'b0, eff_div} - 1'b1;
            tx_shift_nx = tx_head;
            tx_par_nx   = parity_of(tx_head);
        end
    end

    // Line level follows the state one cycle later through txd_q, giving the
    // two-cycle push-to-start latency with glitch-free registered output.
    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift[0];
            S_PAR:   tx_line = tx_par;
            default: tx_line = 1'b1;
        endcase
    end

    assign txd = txd_q;

    // ---------------- RX ----------------
    logic                 rx_s1, rx_sync, rx_prev;
    logic                 rx_empty, rx_full, rx_push, rx_expire;
    logic                 set_frame, set_parity, set_overrun;
    state_t               rx_state, rx_state_nx;
    logic [DIV_W:0]       rx_cnt, rx_cnt_nx, rx_bit_len;
    logic [DIV_W-1:0]     rx_div, rx_div_nx;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
    logic [3:0]           rx_bit, rx_bit_nx;

    uart_bfm_fifo_q #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_ready),
        .rdata (rx_data),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    assign rx_valid    = !rx_empty;
    assign rx_expire   = (rx_cnt == '0);
    assign rx_bit_len  = {1'b0, rx_div} - 1'b1;
    assign set_overrun = rx_push && rx_full && !(rx_ready && !rx_empty);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_s1    <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1    <= rxd;
            rx_sync  <= rx_s1;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_div   <= rx_div_nx;
            rx_shift <= rx_shift_nx;
            rx_bit   <= rx_bit_nx;
        end
    end

    // Edge detect needs rx_prev high, so after a framing error with the line
    // held low the receiver only re-arms once the line has returned high.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_expire ? rx_cnt : rx_cnt - 1'b1;
        rx_div_nx   = rx_div;
        rx_shift_nx = rx_shift;
        rx_bit_nx   = rx_bit;
        rx_push     = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        case (rx_state)
            S_IDLE: if (rx_prev && !rx_sync) begin
                rx_state_nx = S_START;
                rx_div_nx   = eff_div;
                rx_cnt_nx   = {1'b0, eff_div >> 1};
            end
            S_START: if (rx_expire) begin
                if (rx_sync) begin
                    rx_state_nx = S_IDLE;
                end else begin
                    rx_state_nx = S_DATA;
                    rx_cnt_nx   = rx_bit_len;
                    rx_bit_nx   = '0;
                end
            end
            S_DATA: if (rx_expire) begin
                rx_shift_nx = {rx_sync, rx_shift[DATA_BITS-1:1]};
                rx_cnt_nx   = rx_bit_len;
                if (rx_bit == BIT_LAST) begin
                    rx_state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                end else begin
                    rx_bit_nx = rx_bit + 1'b1;
                end
            end
            S_PAR: if (rx_expire) begin
                set_parity  = (rx_sync != parity_of(rx_shift));
                rx_state_nx = S_STOP;
                rx_cnt_nx   = rx_bit_len;
            end
            S_STOP: if (rx_expire) begin
                rx_state_nx = S_IDLE;
                rx_push     = rx_sync;
                set_frame   = !rx_sync;
            end
            default: rx_state_nx = S_IDLE;
        endcase
    end

    // A same-cycle set wins over err_clr.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (set_frame)        err_frame <= 1'b1;
            else if (err_clr)     err_frame <= 1'b0;
            if (set_parity)       err_parity <= 1'b1;
            else if (err_clr)     err_parity <= 1'b0;
            if (set_overrun)      err_overrun <= 1'b1;
            else if (err_clr)     err_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_bfm_fifo.sv
// tb/tb_uart_bfm_fifo.sv - Self-checking bench for uart_bfm_fifo (8N1 instance A, 8E1 depth-4 loopback instance B)
module tb_uart_bfm_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstb;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] a_div, b_div;
    logic        a_loop, a_drv, a_rxd, a_txd, b_line;
    logic [7:0]  a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic        a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready;
    logic        a_rx_valid, b_rx_valid, a_rx_ready, b_rx_ready;
    logic [4:0]  a_tx_count, a_rx_count;
    logic [2:0]  b_tx_count, b_rx_count;
    logic        a_ef, a_ep, a_eo, a_clr, b_ef, b_ep, b_eo, b_clr;

    logic [7:0]  exp_q[$];

    assign a_rxd = a_loop ? a_txd : a_drv;

    uart_bfm_fifo #(.CLKS_PER_BIT(104), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .FIFO_DEPTH(16), .DIV_W(16)) dut_a (
        .clk(clk), .rstb(rstb), .cfg_div(a_div), .rxd(a_rxd), .txd(a_txd),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_count(a_tx_count),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_count(a_rx_count),
        .err_frame(a_ef), .err_parity(a_ep), .err_overrun(a_eo), .err_clr(a_clr));

    uart_bfm_fifo #(.CLKS_PER_BIT(104), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                    .FIFO_DEPTH(4), .DIV_W(16)) dut_b (
        .clk(clk), .rstb(rstb), .cfg_div(b_div), .rxd(b_line), .txd(b_line),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_count(b_tx_count),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_count(b_rx_count),
        .err_frame(b_ef), .err_parity(b_ep), .err_overrun(b_eo), .err_clr(b_clr));

    // Reference line model: bit idx of a frame (0=start, 1..8 data LSB first,
    // 9 parity when mode!=0, remaining stop). mode 1=odd, 2=even.
    function automatic logic frame_bit(input logic [7:0] d, input int mode, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && mode != 0)
            return ($countones(d) % 2 == 1) ? (mode == 2) : (mode == 1);
        return 1'b1;
    endfunction

    task automatic push_byte(input bit sel_b, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!(sel_b ? b_tx_ready : a_tx_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if ((sel_b ? b_tx_ready : a_tx_ready) !== 1'b1) begin
            n_bad++;
            $display("FAIL push_wait tx_ready=%b required=1", sel_b ? b_tx_ready : a_tx_ready);
        end
        if (sel_b) begin b_tx_data = d; b_tx_valid = 1'b1; end
        else       begin a_tx_data = d; a_tx_valid = 1'b1; end
        @(posedge clk);
        #1;
        a_tx_valid = 1'b0;
        b_tx_valid = 1'b0;
    endtask

    task automatic pop_chk(input bit sel_b, input logic [7:0] exp_d);
        logic       v;
        logic [7:0] d;
        @(negedge clk);
        v = sel_b ? b_rx_valid : a_rx_valid;
        d = sel_b ? b_rx_data : a_rx_data;
        n_cmp++;
        if (v !== 1'b1 || d !== exp_d) begin
            n_bad++;
            $display("FAIL pop_%s valid=%b data=%h required valid=1 data=%h", sel_b ? "b" : "a", v, d, exp_d);
        end
        if (sel_b) b_rx_ready = 1'b1; else a_rx_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rx_ready = 1'b0;
        b_rx_ready = 1'b0;
    endtask

    task automatic send_serial(input logic [7:0] d, input logic stop_level);
        for (int b = 0; b < 10; b++) begin
            a_drv = (b == 9) ? stop_level : frame_bit(d, 0, b);
            repeat (16) @(negedge clk);
        end
        a_drv = 1'b1;
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_txd !== 1'b1) begin n_bad++; $display("FAIL rst_txd actual=%b required=1", a_txd); end
        n_cmp++; if (a_tx_ready !== 1'b1 || b_tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_tx_ready actual=%b%b required=11", a_tx_ready, b_tx_ready); end
        n_cmp++; if (a_rx_valid !== 1'b0 || b_rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rx_valid actual=%b%b required=00", a_rx_valid, b_rx_valid); end
        n_cmp++; if (a_tx_count !== 5'd0 || a_rx_count !== 5'd0) begin n_bad++; $display("FAIL rst_counts actual=%0d/%0d required=0/0", a_tx_count, a_rx_count); end
        n_cmp++; if ({a_ef, a_ep, a_eo, b_ef, b_ep, b_eo} !== 6'b0) begin n_bad++; $display("FAIL rst_errs actual=%b required=0", {a_ef, a_ep, a_eo, b_ef, b_ep, b_eo}); end
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_txd !== 1'b1 || b_line !== 1'b1) begin n_bad++; $display("FAIL post_rst_line actual=%b%b required=11", a_txd, b_line); end
    endtask

    task automatic test_tx_a5;
        a_div = 16;
        push_byte(1'b0, 8'hA5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (a_txd !== 1'b1) begin n_bad++; $display("FAIL tx_latency cyc %0d txd=%b required=1", i, a_txd); end
        end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                n_cmp++;
                if (a_txd !== frame_bit(8'hA5, 0, b)) begin
                    n_bad++;
                    $display("FAIL tx_a5 bit %0d cyc %0d txd=%b required=%b", b, c, a_txd, frame_bit(8'hA5, 0, b));
                end
            end
        end
        @(negedge clk);
        n_cmp++; if (a_txd !== 1'b1 || a_tx_count !== 5'd0) begin n_bad++; $display("FAIL tx_a5_end txd=%b count=%0d required 1/0", a_txd, a_tx_count); end
    endtask

    task automatic test_loop_8e1;
        logic [7:0] bytes[3];
        int t = 0;
        bytes[0] = 8'h07; bytes[1] = 8'h00; bytes[2] = 8'hFF;
        b_div = 16;
        for (int i = 0; i < 3; i++) push_byte(1'b1, bytes[i]);
        @(negedge clk);
        while (b_line !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        for (int k = 0; k < 3 * 176; k++) begin
            if (k != 0) @(negedge clk);
            n_cmp++;
            if (b_line !== frame_bit(bytes[k / 176], 2, (k % 176) / 16)) begin
                n_bad++;
                $display("FAIL e1_line k=%0d line=%b required=%b", k, b_line, frame_bit(bytes[k / 176], 2, (k % 176) / 16));
            end
        end
        t = 0;
        while (b_rx_count != 3'd3 && t < 400) begin @(negedge clk); t++; end
        n_cmp++; if (b_rx_count !== 3'd3) begin n_bad++; $display("FAIL e1_rx_count actual=%0d required=3", b_rx_count); end
        n_cmp++; if ({b_ef, b_ep, b_eo} !== 3'b0) begin n_bad++; $display("FAIL e1_errs actual=%b required=000", {b_ef, b_ep, b_eo}); end
        for (int i = 0; i < 3; i++) pop_chk(1'b1, bytes[i]);
    endtask

    task automatic test_frame_err;
        a_loop = 1'b0;
        a_div  = 16;
        send_serial(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        n_cmp++; if (a_ef !== 1'b1) begin n_bad++; $display("FAIL ferr_set actual=%b required=1", a_ef); end
        n_cmp++; if (a_rx_count !== 5'd0 || a_ep !== 1'b0) begin n_bad++; $display("FAIL ferr_count count=%0d ep=%b required 0/0", a_rx_count, a_ep); end
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_ef !== 1'b0) begin n_bad++; $display("FAIL ferr_clr actual=%b required=0", a_ef); end
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        a_div = 16;
        a_drv = 1'b0;
        repeat (3) @(negedge clk);
        a_drv = 1'b1;
        repeat (60) @(negedge clk);
        n_cmp++; if (a_rx_count !== 5'd0) begin n_bad++; $display("FAIL glitch_count actual=%0d required=0", a_rx_count); end
        n_cmp++; if ({a_ef, a_ep, a_eo} !== 3'b0) begin n_bad++; $display("FAIL glitch_errs actual=%b required=000", {a_ef, a_ep, a_eo}); end
        d = 8'($urandom);
        send_serial(d, 1'b1);
        repeat (30) @(negedge clk);
        pop_chk(1'b0, d);
    endtask

    task automatic test_random_loop;
        a_loop = 1'b1;
        for (int it = 0; it < 2; it++) begin
            int n;
            int t = 0;
            int dv;
            dv = (it == 0) ? 0 : int'($urandom_range(24, 6));
            n  = (it == 0) ? 4 : 8;
            a_div = 16'(dv);
            if (dv == 0) dv = 104;
            for (int i = 0; i < n; i++) begin
                logic [7:0] d;
                d = 8'($urandom);
                exp_q.push_back(d);
                push_byte(1'b0, d);
            end
            while (a_rx_count != 5'(n) && t < n * 10 * dv + 300) begin @(negedge clk); t++; end
            n_cmp++; if (a_rx_count !== 5'(n)) begin n_bad++; $display("FAIL rand_count it=%0d actual=%0d required=%0d", it, a_rx_count, n); end
            while (exp_q.size() > 0) pop_chk(1'b0, exp_q.pop_front());
            n_cmp++; if ({a_ef, a_ep, a_eo} !== 3'b0) begin n_bad++; $display("FAIL rand_errs it=%0d actual=%b required=000", it, {a_ef, a_ep, a_eo}); end
        end
        a_loop = 1'b0;
    endtask

    task automatic test_overrun;
        logic [7:0] d[5];
        b_div = 16;
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d[i] = 8'($urandom);
            push_byte(1'b1, d[i]);
        end
        repeat (1000) @(negedge clk);
        n_cmp++; if (b_rx_count !== 3'd4) begin n_bad++; $display("FAIL ovr_count actual=%0d required=4", b_rx_count); end
        n_cmp++; if (b_eo !== 1'b1) begin n_bad++; $display("FAIL ovr_flag actual=%b required=1", b_eo); end
        n_cmp++; if ({b_ef, b_ep} !== 2'b0) begin n_bad++; $display("FAIL ovr_other_errs actual=%b required=00", {b_ef, b_ep}); end
        for (int i = 0; i < 4; i++) pop_chk(1'b1, d[i]);
        @(negedge clk);
        n_cmp++; if (b_rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_empty actual=%b required=0", b_rx_valid); end
    endtask

    task automatic test_reset_midframe;
        a_div = 16;
        for (int i = 0; i < 4; i++) push_byte(1'b0, 8'h00);
        repeat (40) @(negedge clk);
        n_cmp++; if (a_txd !== 1'b0 || a_tx_count !== 5'd3) begin n_bad++; $display("FAIL mid_pre txd=%b count=%0d required 0/3", a_txd, a_tx_count); end
        rstb = 1'b0;
        #1;
        n_cmp++; if (a_txd !== 1'b1) begin n_bad++; $display("FAIL mid_rst_txd actual=%b required=1", a_txd); end
        n_cmp++; if (a_tx_count !== 5'd0 || a_rx_count !== 5'd0) begin n_bad++; $display("FAIL mid_rst_counts actual=%0d/%0d required=0/0", a_tx_count, a_rx_count); end
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++; if (a_txd !== 1'b1) begin n_bad++; $display("FAIL mid_idle cyc %0d txd=%b required=1", i, a_txd); end
        end
    endtask

    initial begin
        rstb = 1'b0;
        a_div = 16; b_div = 16;
        a_loop = 1'b0; a_drv = 1'b1;
        a_tx_data = '0; b_tx_data = '0;
        a_tx_valid = 1'b0; b_tx_valid = 1'b0;
        a_rx_ready = 1'b0; b_rx_ready = 1'b0;
        a_clr = 1'b0; b_clr = 1'b0;
        test_reset;
        test_tx_a5;
        test_loop_8e1;
        test_frame_err;
        test_glitch;
        test_random_loop;
        test_overrun;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
